// File: rtl/main_memory_arbiter_if.sv
// Cache/memory-side signal bundle for main_memory_arbiter.
// The arbiter takes the slave view; the caches plus memory take the master view.
interface main_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  iReadReq;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] iReadData;
  logic                  iDone;
  logic                  dReadReq;
  logic                  dWriteReq;
  logic [ADDR_WIDTH-1:0] dAddress;
  logic [DATA_WIDTH-1:0] dWriteData;
  logic [DATA_WIDTH-1:0] dReadData;
  logic                  dDone;
  logic                  respErr;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  memRead;
  logic                  memWrite;
  logic [DATA_WIDTH-1:0] memReadData;
  logic                  memDataReady;

  modport slave (
    input  iReadReq, iAddress, dReadReq, dWriteReq, dAddress, dWriteData,
           memReadData, memDataReady,
    output iReadData, iDone, dReadData, dDone, respErr,
           memAddress, memWriteData, memRead, memWrite
  );

  modport master (
    output iReadReq, iAddress, dReadReq, dWriteReq, dAddress, dWriteData,
           memReadData, memDataReady,
    input  iReadData, iDone, dReadData, dDone, respErr,
           memAddress, memWriteData, memRead, memWrite
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// Serialises I-cache and D-cache requests onto the single main-memory port.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed data priority.
module main_memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  main_memory_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  win_d;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd, mem_wr;
  logic [DATA_WIDTH-1:0] i_rdata, d_rdata;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  i_done, d_done, resp_err;
  logic                  d_req, grant_d, finish;

  assign d_req    = bus.dReadReq | bus.dWriteReq;
  assign cnt_nxt  = cnt + CW'(1);
  assign finish   = bus.memDataReady | (cnt_nxt == TMO);
  // A timed-out read returns zero rather than whatever is on the bus.
  assign cap_data = bus.memDataReady ? bus.memReadData : '0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  assign grant_d = d_req & (~bus.iReadReq | ~last_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      win_d     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      resp_err  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_req || bus.iReadReq) begin
            state <= BUSY;
            cnt   <= '0;
            win_d <= grant_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d <= grant_d;
`endif
            if (grant_d) begin
              mem_addr  <= bus.dAddress;
              mem_wdata <= bus.dWriteData;
              mem_wr    <= bus.dWriteReq;
              mem_rd    <= ~bus.dWriteReq;
            end else begin
              mem_addr <= bus.iAddress;
              mem_wr   <= 1'b0;
              mem_rd   <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt_nxt;
          if (finish) begin
            state    <= RESP;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            resp_err <= ~bus.memDataReady;
            i_done   <= ~win_d;
            d_done   <= win_d;
            if (mem_rd) begin
              if (win_d) d_rdata <= cap_data;
              else       i_rdata <= cap_data;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          i_done   <= 1'b0;
          d_done   <= 1'b0;
          resp_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.memAddress   = mem_addr;
  assign bus.memWriteData = mem_wdata;
  assign bus.memRead      = mem_rd;
  assign bus.memWrite     = mem_wr;
  assign bus.iReadData    = i_rdata;
  assign bus.dReadData    = d_rdata;
  assign bus.iDone        = i_done;
  assign bus.dDone        = d_done;
  assign bus.respErr      = resp_err;
endmodule
